// File: rtl/serial_request_generator.sv
// serial_request_generator
//   Deserialises bit-strobed serial frames (start, DATA_WIDTH bits LSB-first,
//   optional even parity, stop) and drives a request / inputData / confirm
//   handshake for every good frame. Bad frames pulse frameError and are dropped.
//   Strobes arriving while handshaking are discarded and pulse overrun.
//   Optional feature macro: SRG_PARITY_EN (parity bit present and checked).
module serial_request_generator #(
   parameter int DATA_WIDTH     = 8,
   parameter int SETUP_CYCLES   = 1,
   parameter int CONFIRM_CYCLES = 1,
   parameter int GAP_CYCLES     = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  serialIn,
   input  logic                  bitValid,
   output logic                  request,
   output logic                  confirm,
   output logic [DATA_WIDTH-1:0] inputData,
   output logic                  frameError,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CW = 16;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
`ifdef SRG_PARITY_EN
      PARITY,
`endif
      STOP,
      REQ,
      CONF,
      GAP
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  parity_ok;

`ifdef SRG_PARITY_EN
   logic par;
   // even parity: data ones plus parity bit must be even
   assign parity_ok = ((^shreg) == par);
`else
   assign parity_ok = 1'b1;
`endif

   assign busy = (state != IDLE);

   // frame reception and handshake sequencing, all outputs registered
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         request    <= 1'b0;
         confirm    <= 1'b0;
         inputData  <= '0;
         frameError <= 1'b0;
         overrun    <= 1'b0;
`ifdef SRG_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         frameError <= 1'b0;
         overrun    <= 1'b0;
         case (state)
            IDLE: begin
               if (bitValid && !serialIn) begin
                  state <= DATA;
                  cnt   <= '0;
               end
            end
            DATA: begin
               if (bitValid) begin
                  // shifting in from the top leaves bit i at index i after DATA_WIDTH strobes
                  shreg <= {serialIn, shreg[DATA_WIDTH-1:1]};
                  if (cnt == CW'(DATA_WIDTH - 1)) begin
                     cnt   <= '0;
`ifdef SRG_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
`ifdef SRG_PARITY_EN
            PARITY: begin
               if (bitValid) begin
                  par   <= serialIn;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (bitValid) begin
                  if (serialIn && parity_ok) begin
                     state     <= REQ;
                     request   <= 1'b1;
                     inputData <= shreg;
                     cnt       <= '0;
                  end else begin
                     frameError <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            REQ: begin
               if (bitValid) overrun <= 1'b1;
               if (cnt == CW'(SETUP_CYCLES - 1)) begin
                  cnt     <= '0;
                  confirm <= 1'b1;
                  state   <= CONF;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CONF: begin
               if (bitValid) overrun <= 1'b1;
               if (cnt == CW'(CONFIRM_CYCLES - 1)) begin
                  cnt     <= '0;
                  request <= 1'b0;
                  confirm <= 1'b0;
                  state   <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (bitValid) overrun <= 1'b1;
               if (cnt == CW'(GAP_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
